// File: rtl/vector_sweep_checker.sv
// Exhaustive 4-input stimulus/response checker: steps codes 0..15, holds each
// HOLD_CYCLES cycles, samples dut_y at the end of each hold and logs mismatches.
module vector_sweep_checker #(
    parameter int unsigned  HOLD_CYCLES = 5,
    parameter logic [15:0]  EXPECTED    = 16'h6996
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dut_y,
    output logic [3:0]  vec_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail,
    output logic [15:0] fail_map
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [7:0]  hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  first_q, first_d;
    logic [15:0] map_q, map_d;
    logic        sample_s;
    logic        mismatch_s;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            hold_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            first_q <= 4'd0;
            map_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            map_q   <= map_d;
        end
    end

    // Next-state: sweep sequencing and mismatch logging
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;
        map_d      = map_q;
        sample_s   = (hold_q == HOLD_LAST);
        mismatch_s = (dut_y != EXPECTED[vec_q]);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    vec_d   = 4'd0;
                    hold_d  = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 5'd0;
                    first_d = 4'd0;
                    map_d   = 16'h0000;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (sample_s) begin
                    if (mismatch_s) begin
                        map_d[vec_q] = 1'b1;
                        err_d        = err_q + 5'd1;
                        // err_q still zero means this is the sweep's first failure
                        if (err_q == 5'd0) begin
                            first_d = vec_q;
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (vec_q == 4'd15) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == 5'd0) && !mismatch_s;
                    end else begin
                        vec_d  = vec_q + 4'd1;
                        hold_d = 8'd0;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign vec_out    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_q;
    assign fail_map   = map_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Scoreboard bench: one checker with HOLD_CYCLES=5, one with HOLD_CYCLES=1,
// driven by a bench-side DUT model with selectable fault modes.
module tb_vector_sweep_checker;

    typedef struct packed {
        logic [15:0] map;
        logic [4:0]  errs;
        logic [3:0]  first;
        logic        pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_drv = 1'b0;
    logic use1 = 1'b0;
    int   mode = 0;

    logic start0, start1, y0, y1;
    logic [3:0]  vec0, vec1, first0, first1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [4:0]  err0, err1;
    logic [15:0] map0, map1;

    logic [3:0]  m_vec, m_first;
    logic        m_busy, m_done, m_pass;
    logic [4:0]  m_err;
    logic [15:0] m_map;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic resp(input int md, input logic [3:0] code);
        logic par;
        par = ^code;
        case (md)
            1:       resp = 1'b0;
            2:       resp = (code == 4'd12) ? ~par : par;
            default: resp = par;
        endcase
    endfunction

    function automatic exp_t model_result(input int md);
        exp_t r;
        logic [3:0] c;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            c = 4'(i);
            if (resp(md, c) != ^c) begin
                if (r.errs == 5'd0) r.first = c;
                r.map[i] = 1'b1;
                r.errs   = r.errs + 5'd1;
            end
        end
        r.pass = (r.errs == 5'd0);
        return r;
    endfunction

    assign start0 = start_drv & ~use1;
    assign start1 = start_drv & use1;
    assign y0 = resp(mode, vec0);
    assign y1 = resp(mode, vec1);

    assign m_vec   = use1 ? vec1   : vec0;
    assign m_first = use1 ? first1 : first0;
    assign m_busy  = use1 ? busy1  : busy0;
    assign m_done  = use1 ? done1  : done0;
    assign m_pass  = use1 ? pass1  : pass0;
    assign m_err   = use1 ? err1   : err0;
    assign m_map   = use1 ? map1   : map0;

    vector_sweep_checker #(.HOLD_CYCLES(5), .EXPECTED(16'h6996)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0),
        .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(first0), .fail_map(map0)
    );

    vector_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(16'h6996)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(first1), .fail_map(map1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},   32'(m_vec),   32'd0);
        check({tag, "_busy"},  32'(m_busy),  32'd0);
        check({tag, "_done"},  32'(m_done),  32'd0);
        check({tag, "_pass"},  32'(m_pass),  32'd0);
        check({tag, "_err"},   32'(m_err),   32'd0);
        check({tag, "_first"}, 32'(m_first), 32'd0);
        check({tag, "_map"},   32'(m_map),   32'd0);
    endtask

    // restart_at: edge at which a stray start is pulsed; abort_at: edge at which reset hits
    task automatic run_sweep(input int md, input bit sel1, input int hold,
                             input int restart_at, input int abort_at);
        int   edges;
        bit   got_done;
        bit   aborted;
        exp_t e;
        @(negedge clk);
        mode = md;
        use1 = sel1;
        if (abort_at == 0) sb_q.push_back(model_result(md));
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        check("accept_busy",  32'(m_busy), 32'd1);
        check("accept_done",  32'(m_done), 32'd0);
        check("accept_err",   32'(m_err),  32'd0);
        check("accept_map",   32'(m_map),  32'd0);
        check("accept_pass",  32'(m_pass), 32'd0);
        check("accept_first", 32'(m_first), 32'd0);
        check("accept_vec",   32'(m_vec),  32'd0);
        edges = 0;
        got_done = 1'b0;
        aborted = 1'b0;
        while (!got_done && !aborted && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            start_drv = (edges == restart_at);
            if (edges == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check_all_zero("after_reset");
                aborted = 1'b1;
            end else if (m_done) begin
                got_done = 1'b1;
            end else if (edges % hold == 0) begin
                check("vec_step", 32'(m_vec), 32'(edges / hold));
                check("busy_run", 32'(m_busy), 32'd1);
            end
        end
        start_drv = 1'b0;
        if (!aborted) begin
            check("latency", 32'(edges), 32'(16 * hold));
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("pass",       32'(m_pass),  32'(e.pass));
                check("err_count",  32'(m_err),   32'(e.errs));
                check("first_fail", 32'(m_first), 32'(e.first));
                check("fail_map",   32'(m_map),   32'(e.map));
                check("done_busy",  32'(m_busy),  32'd0);
                check("done_vec",   32'(m_vec),   32'd15);
            end
            repeat (3) @(posedge clk);
            #1;
            check("done_sticky", 32'(m_done), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        use1 = 1'b1;
        #1;
        check_all_zero("reset_h1");
        use1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(0, 1'b0, 5, 0, 0);     // ideal DUT
        run_sweep(1, 1'b0, 5, 0, 0);     // stuck-at-0 output
        run_sweep(0, 1'b0, 5, 20, 0);    // start from DONE, stray start mid-sweep
        run_sweep(2, 1'b0, 5, 0, 0);     // single fault on code 12
        run_sweep(0, 1'b0, 5, 0, 30);    // reset mid-sweep
        run_sweep(0, 1'b0, 5, 0, 0);     // clean sweep after reset
        run_sweep(0, 1'b1, 1, 0, 0);     // HOLD_CYCLES=1 ideal
        run_sweep(2, 1'b1, 1, 0, 0);     // HOLD_CYCLES=1 single fault

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Synthesizable stimulus-and-response engine for small combinational blocks with 4 inputs and 1 output.
- Drives all 16 input codes in ascending order and holds each code for a programmable number of cycles.
- Samples the DUT output at the end of each hold window and compares it against an expected truth table.
- Reports pass/fail, mismatch count, first failing code and a per-code failure map, so exhaustive checks run on-chip or in a bench without $monitor inspection.

Parameters:
- HOLD_CYCLES, 5, cycles each input code is held before dut_y is sampled; legal range 1..255.
- EXPECTED, 16'h6996, expected truth table; bit i is the required dut_y for input code i (default = 4-input XOR).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a sweep; honoured in IDLE or DONE only
- dut_y  input  1  DUT output under test
- vec_out  output  4  DUT input code {a,b,c,d}; MSB = a
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep completion until the next accepted start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  5  number of mismatching codes, 0..16
- first_fail  output  4  lowest failing code; 0 if none
- fail_map  output  16  bit i set iff code i mismatched

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_map=0, hold counter=0. Reset asserted mid-sweep aborts the sweep immediately; no partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge:
  - go to RUN;
  - vec_out=0, hold_cnt=0, busy=1, done=0, pass=0;
  - err_count, first_fail and fail_map are cleared in the same edge.
- start=1 while in RUN is ignored.
- RUN, each edge:
  - if hold_cnt==HOLD_CYCLES-1: sample dut_y and compare with EXPECTED[vec_out].
    - On mismatch: set fail_map[vec_out], increment err_count; if this is the first mismatch of the sweep, first_fail=vec_out.
    - Then if vec_out==15, go to DONE, busy=0, done=1, pass=(no mismatch in the whole sweep, including this one); vec_out holds at 15.
    - Else vec_out+=1 and hold_cnt=0.
  - else hold_cnt+=1.
- Latency: done rises exactly 16*HOLD_CYCLES clock edges after the edge that accepted start. Each code is visible on vec_out for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: the sample occurs on the edge ending the code's single cycle, so the DUT must settle within one cycle.
- err_count saturates naturally at 16 (5-bit, cannot overflow). first_fail is written only once per sweep.
- Outputs are registered and change only on clock edges or reset.
- DONE is sticky: results hold until an accepted start or reset.

Test Plan:
- Ideal DUT (dut_y = parity of vec_out), HOLD_CYCLES=5, start pulse -> vec_out steps 0..15 every 5 cycles; done at 80 edges after start; pass=1, err_count=0, fail_map=16'h0000, first_fail=0.
- dut_y tied 0 -> pass=0, err_count=8, first_fail=1, fail_map=16'h6996.
- dut_y = ~parity on code 12 only -> err_count=1, first_fail=12, fail_map=16'h1000, pass=0.
- rst_n low for 2 cycles at cycle 30 of a sweep -> all outputs 0 immediately (async). Later start -> full clean sweep with results identical to the ideal case.
- start pulsed again at cycle 20 of a sweep -> ignored; done still at cycle 80. Then start from DONE -> done drops, counters clear on that edge, new sweep completes.
- HOLD_CYCLES=1 build, ideal DUT -> each code lasts 1 cycle, done 16 edges after start, pass=1.
